// File: rtl/synchronous_3bit_counter.sv
// Free-running 3-bit synchronous up-counter.
// All three toggle stages share clk, so the bits never ripple.
`timescale 1ns/1ps

module synchronous_3bit_counter (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] out
);

    logic [2:0] q;
    logic [2:0] t;

    // Parallel toggle enables: a bit flips once all lower bits are 1.
    always_comb begin
        t[0] = 1'b1;
        t[1] = q[0];
        t[2] = q[0] & q[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 3'b000;
        end else begin
            q <= q ^ t;
        end
    end

    assign out = q;

endmodule

// File: tb/tb_synchronous_3bit_counter.sv
// Bench for synchronous_3bit_counter: directed plan plus random resets,
// checked against an integer count kept modulo 8.
`timescale 1ns/1ps

module tb_synchronous_3bit_counter;

    logic       clk;
    logic       rst;
    logic [2:0] out;

    int unsigned cnt;
    int          passed;
    int          total;

    synchronous_3bit_counter dut (
        .clk (clk),
        .rst (rst),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [2:0] exp);
        total++;
        assert (out === exp) passed++;
        else $error("FAIL %s: observed=%b expected=%b", tag, out, exp);
    endtask

    // One rising edge; the model counts only while reset is released.
    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        if (rst === 1'b1) cnt = cnt + 1;
        check(tag, 3'(cnt % 8));
    endtask

    // Assert reset between edges and expect an immediate clear.
    task automatic assert_reset(input string tag, input int dly);
        @(negedge clk);
        #(dly);
        rst = 1'b0;
        #1;
        cnt = 0;
        check(tag, 3'b000);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        cnt    = 0;
        rst    = 1'b0;

        #2;
        check("reset_initial", 3'b000);
        tick("reset_hold_1");
        tick("reset_hold_2");

        release_reset();
        #1;
        check("release_no_edge", 3'b000);
        for (int i = 0; i < 7; i++) tick("basic_count");
        check("basic_at_111", 3'b111);

        tick("wrap_to_000");
        check("wrap_value", 3'b000);
        tick("wrap_then_001");

        for (int i = 0; i < 8 && (cnt % 8) != 5; i++) tick("run_to_101");
        check("at_101", 3'b101);
        assert_reset("async_reset_mid", 2);
        for (int i = 0; i < 3; i++) tick("reset_held_edges");

        release_reset();
        #1;
        check("long_start", 3'b000);
        for (int i = 0; i < 20; i++) tick("long_run_step");
        check("long_final_100", 3'b100);

        for (int i = 0; i < 8 && (cnt % 8) != 7; i++) tick("run_to_111");
        check("terminal_111", 3'b111);
        assert_reset("rereset_at_111", 0);
        #10;
        rst = 1'b1;
        #1;
        check("rereset_released", 3'b000);
        tick("restart_001");
        check("restart_value", 3'b001);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                assert_reset("rand_reset", int'($urandom_range(1, 3)));
                repeat ($urandom_range(0, 2)) tick("rand_reset_hold");
                release_reset();
                #1;
                check("rand_release", 3'b000);
            end else begin
                tick("rand_count");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
